// File: rtl/accumulate_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : accumulate_arbiter
// Description : Two requesters share one multiply-by-repeated-addition
//               datapath (Sum += X, Y times). A round-robin arbiter picks a
//               job in IDLE, the RUN state accumulates, and DONE pulses Done
//               for one cycle while the final Sum is presented.
// Revision    : 1.0 - initial release
// ============================================================================
module accumulate_arbiter #(
  parameter int N_WIDTH = 5,   // width of each addend / repeat count
  parameter int S_WIDTH = 10   // width of Sum, at least 2*N_WIDTH
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [1:0]         Req,
  input  logic [N_WIDTH-1:0] X0,
  input  logic [N_WIDTH-1:0] Y0,
  input  logic [N_WIDTH-1:0] X1,
  input  logic [N_WIDTH-1:0] Y1,
  output logic [1:0]         Grant,
  output logic               Busy,
  output logic               Done,
  output logic               Owner,
  output logic [S_WIDTH-1:0] Sum
);

  // Sequencer states
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [N_WIDTH-1:0] c_count_one = N_WIDTH'(1);

  logic [1:0]         r_state;
  logic [N_WIDTH-1:0] r_xl;      // latched addend of the granted job
  logic [N_WIDTH-1:0] r_count;   // remaining additions
  logic [S_WIDTH-1:0] r_sum;
  logic [1:0]         r_grant;
  logic               r_busy;
  logic               r_done;
  logic               r_owner;
  logic               r_last;    // most recently granted requester

  logic               w_win;
  logic [N_WIDTH-1:0] w_x_sel;
  logic [N_WIDTH-1:0] w_y_sel;
  logic [S_WIDTH-1:0] w_addend;

  // A lone request wins outright; on a tie the requester not served last wins.
  assign w_win    = (Req == 2'b11) ? ~r_last : Req[1];
  assign w_x_sel  = w_win ? X1 : X0;
  assign w_y_sel  = w_win ? Y1 : Y0;
  assign w_addend = {{(S_WIDTH-N_WIDTH){1'b0}}, r_xl};

  // Arbitration, job load, accumulation and completion sequencing.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_xl    <= '0;
      r_count <= '0;
      r_sum   <= '0;
      r_grant <= 2'b00;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_owner <= 1'b0;
      r_last  <= 1'b1;   // so requester 0 wins the first tie
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Req != 2'b00) begin
            r_xl    <= w_x_sel;
            r_count <= w_y_sel;
            r_sum   <= '0;
            r_grant <= w_win ? 2'b10 : 2'b01;
            r_owner <= w_win;
            r_last  <= w_win;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_count != '0) begin
            r_sum   <= r_sum + w_addend;
            r_count <= r_count - c_count_one;
          end else begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_grant <= 2'b00;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_grant <= 2'b00;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign Grant = r_grant;
  assign Busy  = r_busy;
  assign Done  = r_done;
  assign Owner = r_owner;
  assign Sum   = r_sum;

endmodule
`default_nettype wire

// File: tb/tb_accumulate_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_accumulate_arbiter
// Description : Directed, table-driven bench for accumulate_arbiter with
//               hand-written sequences for alternation, operand change,
//               request drop and mid-job reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_accumulate_arbiter;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [1:0] Req   = 2'b00;
  logic [4:0] X0 = '0, Y0 = '0, X1 = '0, Y1 = '0;
  logic [1:0] Grant;
  logic       Busy, Done, Owner;
  logic [9:0] Sum;

  int n_checks = 0;
  int n_errors = 0;

  accumulate_arbiter #(.N_WIDTH(5), .S_WIDTH(10)) dut (
    .Clock(Clock), .Reset(Reset), .Req(Req),
    .X0(X0), .Y0(Y0), .X1(X1), .Y1(Y1),
    .Grant(Grant), .Busy(Busy), .Done(Done), .Owner(Owner), .Sum(Sum)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [1:0] req;
    logic [4:0] x0, y0, x1, y1;
    logic [1:0] grant;
    int         sum;
    int         owner;
    int         len;    // cycle index of the Done pulse
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    Req   = 2'b00;
    step();
    Reset = 1'b0;
  endtask

  // Called in the cycle where Req is sampled (cycle 0). Returns in the first
  // IDLE cycle after DONE. chg_kind 1: X0=31,Y0=1 at chg_cyc; 2: Req dropped.
  task automatic run_job(input string tag, input logic [1:0] exp_grant,
                         input int exp_sum, input int exp_owner,
                         input int exp_len, input int chg_cyc,
                         input int chg_kind);
    int cyc = 0;
    do begin
      step();
      cyc++;
      if (cyc == chg_cyc && chg_kind == 1) begin X0 = 5'd31; Y0 = 5'd1; end
      if (cyc == chg_cyc && chg_kind == 2) Req = 2'b00;
      if (cyc == 1) begin
        chk({tag, " grant@1"}, int'(Grant), int'(exp_grant));
        chk({tag, " busy@1"}, int'(Busy), 1);
        chk({tag, " owner@1"}, int'(Owner), exp_owner);
      end
    end while (!Done && cyc < 80);
    chk({tag, " done cycle"}, cyc, exp_len);
    chk({tag, " sum"}, int'(Sum), exp_sum);
    chk({tag, " owner"}, int'(Owner), exp_owner);
    chk({tag, " grant@done"}, int'(Grant), int'(exp_grant));
    step();
    chk({tag, " grant idle"}, int'(Grant), 0);
    chk({tag, " busy idle"}, int'(Busy), 0);
    chk({tag, " done pulse"}, int'(Done), 0);
    chk({tag, " sum hold"}, int'(Sum), exp_sum);
  endtask

  initial begin
    vecs[0] = '{req:2'b01, x0:5, y0:3, x1:0, y1:0, grant:2'b01, sum:15, owner:0, len:5};
    vecs[1] = '{req:2'b10, x0:0, y0:0, x1:9, y1:0, grant:2'b10, sum:0, owner:1, len:2};
    vecs[2] = '{req:2'b01, x0:31, y0:31, x1:0, y1:0, grant:2'b01, sum:961, owner:0, len:33};
    vecs[3] = '{req:2'b10, x0:1, y0:1, x1:6, y1:5, grant:2'b10, sum:30, owner:1, len:7};
    vecs[4] = '{req:2'b11, x0:2, y0:4, x1:7, y1:2, grant:2'b01, sum:8, owner:0, len:6};

    do_reset();
    chk("reset grant", int'(Grant), 0);
    chk("reset busy", int'(Busy), 0);
    chk("reset done", int'(Done), 0);
    chk("reset sum", int'(Sum), 0);
    chk("reset owner", int'(Owner), 0);

    for (int i = 0; i < 5; i++) begin
      do_reset();
      X0 = vecs[i].x0; Y0 = vecs[i].y0; X1 = vecs[i].x1; Y1 = vecs[i].y1;
      Req = vecs[i].req;
      run_job($sformatf("vec%0d", i), vecs[i].grant, vecs[i].sum,
              vecs[i].owner, vecs[i].len, 0, 0);
    end

    // Reset after a nonzero result must clear Sum and Owner.
    Req = 2'b00;
    do_reset();
    chk("reset2 sum", int'(Sum), 0);
    chk("reset2 owner", int'(Owner), 0);

    // Strict alternation with both requests held throughout.
    X0 = 5'd2; Y0 = 5'd4; X1 = 5'd7; Y1 = 5'd2;
    Req = 2'b11;
    run_job("alt0", 2'b01, 8, 0, 6, 0, 0);
    run_job("alt1", 2'b10, 14, 1, 4, 0, 0);
    run_job("alt2", 2'b01, 8, 0, 6, 0, 0);

    // Operands changed mid-job are ignored.
    do_reset();
    X0 = 5'd3; Y0 = 5'd10; Req = 2'b01;
    run_job("opchg", 2'b01, 30, 0, 12, 2, 1);

    // Request dropped mid-job: job still completes.
    do_reset();
    X1 = 5'd3; Y1 = 5'd4; Req = 2'b10;
    run_job("reqdrop", 2'b10, 12, 1, 6, 2, 2);

    // Reset in the middle of a job, then restart with Req still high.
    do_reset();
    X0 = 5'd4; Y0 = 5'd8; Req = 2'b01;
    for (int c = 1; c <= 4; c++) begin
      step();
      chk($sformatf("midrst done@%0d", c), int'(Done), 0);
    end
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("midrst grant", int'(Grant), 0);
    chk("midrst busy", int'(Busy), 0);
    chk("midrst sum", int'(Sum), 0);
    chk("midrst done", int'(Done), 0);
    run_job("restart", 2'b01, 32, 0, 10, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/accumulate_arbiter.md
Name: accumulate_arbiter

Overview:
- Shares one multiply-by-repeated-addition datapath (Sum += X, Y times) between two requesters.
- Round-robin arbitration, then sequences a load/run/done cycle for the granted job.
- Request/done handshake; result held on Sum.
- Sits between switch/peripheral-driven requesters and the LEDR/result display path.

Parameters:
- N_WIDTH, 5, width of each X (addend) and Y (repeat count) operand.
- S_WIDTH, 10, width of Sum. Must be >= 2*N_WIDTH, so no overflow is possible.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- Req  in  2  Req[i] = requester i wants a job; level, held until Done seen.
- X0  in  N_WIDTH  addend for requester 0.
- Y0  in  N_WIDTH  repeat count for requester 0.
- X1  in  N_WIDTH  addend for requester 1.
- Y1  in  N_WIDTH  repeat count for requester 1.
- Grant  out  2  one-hot owner of the datapath; 00 when idle.
- Busy  out  1  1 in RUN or DONE.
- Done  out  1  one-cycle pulse, final Sum valid.
- Owner  out  1  index of the requester whose result is on Sum.
- Sum  out  S_WIDTH  accumulated result.

Behaviour:
- Interface (already decided): one clock, Clock; reset is synchronous and active-high, Reset.
- Reset has priority over everything, including mid-job:
  - state=IDLE; Sum=0, Count=0, Grant=00, Busy=0, Done=0, Owner=0.
  - Round-robin pointer Last=1, so requester 0 wins the first tie.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE, Req==00: stay; Sum and Owner hold the previous result.
- IDLE, Req!=00: pick the winner W.
  - Only one bit set: that requester.
  - Both set: W = ~Last.
- IDLE-to-RUN edge:
  - XL<=X_W, Count<=Y_W, Sum<=0, Grant<=onehot(W), Owner<=W, Last<=W, Busy<=1, state<=RUN.
- RUN:
  - Count!=0: Sum<=Sum+XL (zero-extended to S_WIDTH), Count<=Count-1.
  - Count==0: state<=DONE, Done<=1.
  - RUN lasts Y_W+1 cycles.
- DONE (exactly 1 cycle): Done=1, Sum final, Grant still asserted.
  - Next: state<=IDLE, Grant<=00, Busy<=0, Done<=0.
- Latency: Req sampled in IDLE at cycle 0; RUN occupies cycles 1..Y+1; Done=1 at cycle Y+2.
- Req is ignored in RUN and DONE.
- A requester still asserting Req in the first IDLE cycle after DONE is re-arbitrated normally.
  - If both are requesting, the other requester wins (Last updated).
  - Back-to-back jobs therefore have one IDLE cycle between DONE and the next RUN.
- X/Y inputs are sampled only on the IDLE-to-RUN edge; changes during RUN/DONE have no effect.
- Y=0: RUN lasts 1 cycle with no add, Done at cycle 2, Sum=0.
- Request deasserted mid-job: the job still completes; Done still pulses.
- Sum never wraps: max (2^N_WIDTH-1)^2 < 2^S_WIDTH.
- Invariants:
  - Grant is one-hot or zero.
  - Busy == (Grant!=0).
  - Done implies state DONE.

Test Plan:
- Reset, then Req=01 with X0=5, Y0=3 held → Grant=01 from cycle 1; Done pulse at cycle 5; Sum=15, Owner=0; Grant=00 at cycle 6.
- After reset, Req=11 with X0=2,Y0=4, X1=7,Y1=2 held until each Done:
  - Requester 0 served first: Sum=8 at its Done.
  - One IDLE cycle, then requester 1: Sum=14, Owner=1.
  - Keep both asserted for a third job → requester 0 served again (strict alternation).
- Req=10, X1=9, Y1=0 → Done at cycle 2, Sum=0, Owner=1.
- Req=01, X0=31, Y0=31 → Done at cycle 33, Sum=961, no overflow.
- Req=01, X0=3, Y0=10; change X0=31, Y0=1 at cycle 2 → Sum=30 at Done (cycle 12); new operands ignored.
- Req=01, X0=4, Y0=8; assert Reset at cycle 4 for 1 cycle:
  - Next cycle: Grant=00, Busy=0, Sum=0, Done never pulses for that job.
  - Req still high → new job restarts with Sum=32 at its Done.
